// File: rtl/result_writeback_if.sv
// result_writeback_if
//   Bundles the control, lane-input and result-memory write signals of the
//   result_writeback stage. The master modport belongs to whoever drives
//   start/lanes and acts as the memory (testbench or system glue). The slave
//   modport belongs to result_writeback.
//
//   Signals
//     start, base_addr, num_results, shift, relu_en   run control (to DUT)
//     acc_in_0..3, valid_in                           lane results + strobes (to DUT)
//     wr_ready                                        memory accepts this cycle (to DUT)
//     wr_en, wr_addr, wr_data                         write request (from DUT)
//     busy, done, overflow                            status (from DUT)
//     state_dbg                                       FSM state, 0 = IDLE, 1 = RUN (from DUT)
//
//   Write handshake: wr_en is the valid. Once wr_en is high, wr_en, wr_addr
//   and wr_data hold steady until a cycle with wr_ready high. A word transfers
//   on every rising edge where wr_en && wr_ready. wr_ready may be high while
//   wr_en is low, and this has no effect.
interface result_writeback_if #(
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int N_MACS = 4,
    parameter int ADDR_W = 8
);
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [ADDR_W-1:0]        num_results;
    logic [3:0]               shift;
    logic                     relu_en;
    logic signed [ACC_W-1:0]  acc_in_0;
    logic signed [ACC_W-1:0]  acc_in_1;
    logic signed [ACC_W-1:0]  acc_in_2;
    logic signed [ACC_W-1:0]  acc_in_3;
    logic [N_MACS-1:0]        valid_in;
    logic                     wr_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [OUT_W-1:0]         wr_data;
    logic                     busy;
    logic                     done;
    logic                     overflow;
    logic                     state_dbg;

    modport master (
        output start, base_addr, num_results, shift, relu_en,
        output acc_in_0, acc_in_1, acc_in_2, acc_in_3, valid_in, wr_ready,
        input  wr_en, wr_addr, wr_data, busy, done, overflow, state_dbg
    );

    modport slave (
        input  start, base_addr, num_results, shift, relu_en,
        input  acc_in_0, acc_in_1, acc_in_2, acc_in_3, valid_in, wr_ready,
        output wr_en, wr_addr, wr_data, busy, done, overflow, state_dbg
    );
endinterface

// File: rtl/result_writeback.sv
// result_writeback
//   Downstream stage of the MAC array. Captures per-lane accumulator results
//   when their strobe pulses, requantizes each one (arithmetic shift, optional
//   ReLU, saturation to OUT_W bits) and writes them one per handshake into the
//   result memory. Addresses count up from base_addr, wrapping at 2^ADDR_W,
//   until num_results words have been written.
//
//   Ports
//     clk   system clock
//     rst   synchronous reset, active-high; aborts any run immediately
//     bus   result_writeback_if.slave (run control, lanes, write port, status)
//
//   The lane count is fixed at 4 (acc_in_0..acc_in_3).
module result_writeback #(
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int N_MACS = 4,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    result_writeback_if.slave  bus
);
    localparam int SEL_W = $clog2(N_MACS);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       num_q;
    logic [3:0]              shift_q;
    logic                    relu_q;
    logic [ADDR_W-1:0]       count;    // words accepted by memory this run
    logic [ADDR_W-1:0]       loaded;   // words put in the output register this run
    logic [N_MACS-1:0]       pending;
    logic signed [ACC_W-1:0] hold [N_MACS];
    logic signed [ACC_W-1:0] acc_vec [N_MACS];

    logic                    wr_en_q;
    logic [ADDR_W-1:0]       wr_addr_q;
    logic [OUT_W-1:0]        wr_data_q;
    logic                    done_q;
    logic                    overflow_q;

    logic                    xfer;
    logic                    out_free;
    logic                    last_xfer;
    logic                    do_load;
    logic [SEL_W-1:0]        sel;
    logic [N_MACS-1:0]       drain_mask;

    assign acc_vec[0] = bus.acc_in_0;
    assign acc_vec[1] = bus.acc_in_1;
    assign acc_vec[2] = bus.acc_in_2;
    assign acc_vec[3] = bus.acc_in_3;

    // Floor shift, then ReLU, then clamp into the signed OUT_W range.
    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                                 input logic [3:0]              sh,
                                                 input logic                    relu);
        logic signed [ACC_W-1:0] y;
        y = acc >>> sh;
        if (relu && y[ACC_W-1]) y = '0;
        if (y > SAT_MAX) y = SAT_MAX;
        else if (y < SAT_MIN) y = SAT_MIN;
        return y[OUT_W-1:0];
    endfunction

    always_comb begin
        xfer       = wr_en_q && bus.wr_ready;
        out_free   = !wr_en_q || bus.wr_ready;
        last_xfer  = xfer && ((count + ONE) == num_q);
        sel        = '0;
        drain_mask = '0;
        // Highest index first so the lowest pending lane wins.
        for (int i = N_MACS - 1; i >= 0; i--) begin
            if (pending[i]) sel = SEL_W'(i);
        end
        // Stop loading once every word this run needs has been loaded; later
        // captures simply stay pending until the run ends.
        do_load = (state == RUN) && out_free && (|pending) && (loaded != num_q);
        if (do_load) drain_mask[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            num_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            count      <= '0;
            loaded     <= '0;
            pending    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N_MACS; i++) hold[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        num_q      <= bus.num_results;
                        shift_q    <= bus.shift;
                        relu_q     <= bus.relu_en;
                        wr_addr_q  <= bus.base_addr;
                        count      <= '0;
                        loaded     <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    // A lane drained on this edge sends its old value out, so a
                    // simultaneous capture there is not a loss.
                    for (int i = 0; i < N_MACS; i++) begin
                        if (bus.valid_in[i]) begin
                            hold[i] <= acc_vec[i];
                            if (pending[i] && !drain_mask[i]) overflow_q <= 1'b1;
                        end
                    end
                    pending <= (pending & ~drain_mask) | bus.valid_in;

                    if (do_load) begin
                        wr_data_q <= requant(hold[sel], shift_q, relu_q);
                        wr_en_q   <= 1'b1;
                        loaded    <= loaded + ONE;
                    end else if (xfer) begin
                        wr_en_q <= 1'b0;
                    end

                    // wr_addr always names the word in (or next into) the
                    // output register, so it advances on each accepted word.
                    if (xfer) begin
                        wr_addr_q <= wr_addr_q + ONE;
                        count     <= count + ONE;
                    end

                    if (last_xfer || (num_q == '0)) begin
                        state   <= IDLE;
                        done_q  <= 1'b1;
                        wr_en_q <= 1'b0;
                        pending <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_result_writeback.sv
`timescale 1ns/1ps
module tb_result_writeback;
    localparam int ACC_W  = 16;
    localparam int OUT_W  = 8;
    localparam int N_MACS = 4;
    localparam int ADDR_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_writeback_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .N_MACS(N_MACS), .ADDR_W(ADDR_W)) bus ();

    result_writeback #(.ACC_W(ACC_W), .OUT_W(OUT_W), .N_MACS(N_MACS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [15:0]      exp_q[$];   // {addr, data} in write order
    logic [OUT_W-1:0] got_q[$];   // data actually accepted, for literal checks
    logic [1:0]       done_pipe;  // bit0: done expected at the next sample
    int               model_left;
    logic             cmp_exp_done;
    logic [15:0]      cmp_e;
    logic             prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [OUT_W-1:0]  prev_data;
    logic [7:0]       t2_data [4];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Requantize from the arithmetic rules: floor shift, ReLU, clamp.
    function automatic int model_q(input int acc, input int sh, input bit relu);
        int y;
        y = acc >>> sh;
        if (relu && y < 0) y = 0;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y & 255;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_pipe  = '0;
            model_left = 0;
            prev_stall = 1'b0;
        end else begin
            cmp_exp_done = done_pipe[0];
            done_pipe    = done_pipe >> 1;
            check("done", bus.done, cmp_exp_done);
            check("wr_en_idle", bus.wr_en & ~bus.busy, 0);
            if (prev_stall) begin
                check("stall_wr_en", bus.wr_en, 1);
                check("stall_wr_addr", bus.wr_addr, prev_addr);
                check("stall_wr_data", bus.wr_data, prev_data);
            end
            if (bus.wr_en && bus.wr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr, cmp_e[15:8]);
                    check("wr_data", bus.wr_data, cmp_e[7:0]);
                end
                got_q.push_back(bus.wr_data);
                if (model_left == 1) done_pipe[0] = 1'b1;
                if (model_left > 0) model_left--;
            end
            if (bus.start && !bus.busy) begin
                model_left = bus.num_results;
                if (bus.num_results == 0) done_pipe[1] = 1'b1;
            end
            prev_stall = bus.wr_en && !bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] base, input logic [7:0] n,
                             input logic [3:0] sh, input logic relu);
        bus.base_addr   = base;
        bus.num_results = n;
        bus.shift       = sh;
        bus.relu_en     = relu;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        // Scramble the run inputs so a design that resamples them would show it.
        bus.base_addr   = ~base;
        bus.num_results = 8'hFF;
        bus.shift       = ~sh;
        bus.relu_en     = ~relu;
    endtask

    task automatic capture(input int a0, input int a1, input int a2, input int a3,
                           input logic [3:0] mask);
        bus.acc_in_0 = ACC_W'(a0);
        bus.acc_in_1 = ACC_W'(a1);
        bus.acc_in_2 = ACC_W'(a2);
        bus.acc_in_3 = ACC_W'(a3);
        bus.valid_in = mask;
        tick();
        bus.valid_in = '0;
    endtask

    task automatic push_exp(input logic [7:0] addr, input int acc, input int sh, input bit relu);
        logic [7:0] d;
        d = 8'(model_q(acc, sh, relu));
        exp_q.push_back({addr, d});
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.busy && k < 50) begin
            tick();
            k++;
        end
        check({name, "_timeout"}, bus.busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_got(input string name, input int idx, input logic [7:0] expv);
        if (got_q.size() > idx) check(name, got_q[idx], expv);
        else check({name, "_missing"}, got_q.size(), idx + 1);
    endtask

    // One run with all lanes in mask captured on the same cycle.
    task automatic do_run(input string name, input logic [7:0] base, input logic [7:0] n,
                          input logic [3:0] sh, input logic relu,
                          input int a0, input int a1, input int a2, input int a3,
                          input logic [3:0] mask);
        int acc [4];
        int idx;
        acc = '{a0, a1, a2, a3};
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && idx < int'(n)) begin
                push_exp(8'(base + idx), acc[i], sh, relu);
                idx++;
            end
        end
        got_q.delete();
        start_run(base, n, sh, relu);
        capture(a0, a1, a2, a3, mask);
        wait_idle(name);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        t2_data = '{8'd25, 8'hE7, 8'd2, 8'd0};
        bus.start = 1'b0; bus.base_addr = '0; bus.num_results = '0; bus.shift = '0;
        bus.relu_en = 1'b0; bus.acc_in_0 = '0; bus.acc_in_1 = '0; bus.acc_in_2 = '0;
        bus.acc_in_3 = '0; bus.valid_in = '0; bus.wr_ready = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_state", bus.state_dbg, 0);

        // 1: reset in the middle of a stalled run
        start_run(8'h40, 8'd4, 4'd0, 1'b0);
        capture(1, 2, 3, 4, 4'hF);
        tick();
        check("t1_pre_wr_en", bus.wr_en, 1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("t1_wr_en", bus.wr_en, 0);
        check("t1_busy", bus.busy, 0);
        check("t1_done", bus.done, 0);
        check("t1_overflow", bus.overflow, 0);
        check("t1_state", bus.state_dbg, 0);
        bus.wr_ready = 1'b1;
        repeat (3) tick();

        // 2: basic run, latency and throughput
        for (int k = 0; k < 4; k++) begin
            push_exp(8'(8'h10 + k), (k == 0) ? 100 : (k == 1) ? -100 : (k == 2) ? 8 : 3, 2, 1'b0);
        end
        got_q.delete();
        start_run(8'h10, 8'd4, 4'd2, 1'b0);
        capture(100, -100, 8, 3, 4'hF);
        check("t2_lat_t1", bus.wr_en, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t2_wr_en", bus.wr_en, 1);
            check("t2_wr_addr", bus.wr_addr, 8'h10 + k);
            check("t2_wr_data", bus.wr_data, t2_data[k]);
            tick();
        end
        check("t2_done", bus.done, 1);
        check("t2_busy", bus.busy, 0);
        wait_idle("t2");

        // 3: saturation, ReLU, floor shift
        do_run("t3a", 8'h50, 8'd2, 4'd0, 1'b0, 300, -300, 0, 0, 4'b0011);
        check_got("t3a_pos_sat", 0, 8'd127);
        check_got("t3a_neg_sat", 1, 8'h80);
        do_run("t3b", 8'h60, 8'd4, 4'd0, 1'b1, 300, -300, -1, 5, 4'hF);
        check_got("t3b_pos_sat", 0, 8'd127);
        check_got("t3b_relu_sat", 1, 8'd0);
        check_got("t3b_relu_m1", 2, 8'd0);
        check_got("t3b_pass", 3, 8'd5);
        do_run("t3c", 8'h70, 8'd4, 4'd1, 1'b0, -1, 7, -7, 32767, 4'hF);
        check_got("t3c_m1_shift", 0, 8'hFF);
        check_got("t3c_floor_pos", 1, 8'd3);
        check_got("t3c_floor_neg", 2, 8'hFC);
        check_got("t3c_big", 3, 8'd127);

        // 4: backpressure and overflow
        bus.wr_ready = 1'b0;
        push_exp(8'h20, 10, 0, 1'b0);
        push_exp(8'h21, 21, 0, 1'b0);
        push_exp(8'h22, 30, 0, 1'b0);
        start_run(8'h20, 8'd3, 4'd0, 1'b0);
        capture(10, 20, 0, 0, 4'b0011);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_en", bus.wr_en, 1);
            check("t4_hold_addr", bus.wr_addr, 8'h20);
            check("t4_hold_data", bus.wr_data, 8'd10);
            tick();
        end
        check("t4_no_ovf_yet", bus.overflow, 0);
        capture(0, 21, 0, 0, 4'b0010);
        check("t4_overflow", bus.overflow, 1);
        capture(0, 0, 30, 0, 4'b0100);
        bus.wr_ready = 1'b1;
        wait_idle("t4");
        check("t4_ovf_sticky", bus.overflow, 1);

        // 4b: capture and drain of the same lane on one edge is not an overflow
        push_exp(8'h08, 4, 0, 1'b0);
        push_exp(8'h09, 5, 0, 1'b0);
        start_run(8'h08, 8'd2, 4'd0, 1'b0);
        check("t4b_ovf_cleared", bus.overflow, 0);
        capture(4, 0, 0, 0, 4'b0001);
        capture(5, 0, 0, 0, 4'b0001);
        wait_idle("t4b");
        check("t4b_no_ovf", bus.overflow, 0);

        // 5: address wrap, then an empty run
        do_run("t5", 8'hFE, 8'd3, 4'd0, 1'b0, 0, 1, 2, 3, 4'b1110);
        check_got("t5_d0", 0, 8'd1);
        check_got("t5_d2", 2, 8'd3);
        start_run(8'h55, 8'd0, 4'd0, 1'b0);
        check("t5_zero_busy", bus.busy, 1);
        check("t5_zero_done_early", bus.done, 0);
        tick();
        check("t5_zero_idle", bus.busy, 0);
        check("t5_zero_done", bus.done, 1);
        check("t5_zero_wr_en", bus.wr_en, 0);
        tick();
        check("t5_zero_done_pulse", bus.done, 0);

        // 6: valid_in in IDLE, start during RUN, surplus discard
        capture(11, 22, 33, 44, 4'hF);
        tick();
        check("t6_idle_wr_en", bus.wr_en, 0);
        check("t6_idle_busy", bus.busy, 0);
        got_q.delete();
        push_exp(8'h30, -8, 1, 1'b0);
        push_exp(8'h31, 6, 1, 1'b0);
        start_run(8'h30, 8'd2, 4'd1, 1'b0);
        bus.base_addr = 8'h90; bus.num_results = 8'd5; bus.shift = 4'd0; bus.relu_en = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        capture(0, -8, 6, 9, 4'b1110);
        wait_idle("t6");
        check_got("t6_d0", 0, 8'hFC);
        check_got("t6_d1", 1, 8'd3);
        check("t6_count", got_q.size(), 2);
        push_exp(8'hA0, 77, 0, 1'b0);
        start_run(8'hA0, 8'd1, 4'd0, 1'b0);
        repeat (3) tick();
        capture(77, 0, 0, 0, 4'b0001);
        wait_idle("t6b");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
